// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone widths and arbiter state encoding
package wb_pkg;
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1, ARB_ABORT} arb_state_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: Wishbone classic bus bundle with master/slave views
interface wb_arbiter_if import wb_pkg::*; ();
  logic                cyc;
  logic                stb;
  logic                we;
  logic [WB_SEL_W-1:0] sel;
  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] dat_w;
  logic [WB_DAT_W-1:0] dat_r;
  logic                ack;
  logic                err;
  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, err);
  modport slave (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_watchdog.sv
// wb_watchdog: counts stalled strobe cycles and flags expiry on the last allowed one
module wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  logic [TO_WIDTH-1:0] cnt;
  assign expire = inc && cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : inc ? cnt + TO_WIDTH'(1) : cnt;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master round-robin Wishbone arbiter with bus-timeout abort
module wb_arbiter import wb_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  m0,
  wb_arbiter_if.slave  m1,
  wb_arbiter_if.master wb,
  output logic [1:0]   gnt
);
  arb_state_t state;
  logic last_gnt, granted, sel1, cyc_x, stb_x, ack_ok, inc, expire, last_cyc;
  assign granted = state == ARB_GNT0 || state == ARB_GNT1;
  assign sel1 = state == ARB_GNT1;
  assign cyc_x = granted && (sel1 ? m1.cyc : m0.cyc);
  assign stb_x = cyc_x && (sel1 ? m1.stb : m0.stb);
  assign ack_ok = stb_x && wb.ack;
  assign inc = stb_x && !wb.ack;
  assign last_cyc = last_gnt ? m1.cyc : m0.cyc;
  always_comb begin
    wb.cyc = cyc_x;
    wb.stb = stb_x;
    wb.we = cyc_x && (sel1 ? m1.we : m0.we);
    wb.sel = cyc_x ? (sel1 ? m1.sel : m0.sel) : '0;
    wb.adr = cyc_x ? (sel1 ? m1.adr : m0.adr) : '0;
    wb.dat_w = cyc_x ? (sel1 ? m1.dat_w : m0.dat_w) : '0;
    m0.dat_r = wb.dat_r;
    m1.dat_r = wb.dat_r;
    m0.ack = ack_ok && !sel1;
    m1.ack = ack_ok && sel1;
    m0.err = expire && !sel1;
    m1.err = expire && sel1;
  end
  wb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_WIDTH(TO_WIDTH)) u_wd (
    .clk(clk), .rst(rst), .clr(!inc || expire), .inc(inc), .expire(expire)
  );
  // ABORT remembers the offending master through last_gnt, set on grant entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      last_gnt <= 1'b1;
      gnt <= 2'b00;
    end else begin
      unique case (state)
        ARB_IDLE:
          if (m0.cyc && (!m1.cyc || last_gnt)) begin
            state <= ARB_GNT0;
            last_gnt <= 1'b0;
            gnt <= 2'b01;
          end else if (m1.cyc) begin
            state <= ARB_GNT1;
            last_gnt <= 1'b1;
            gnt <= 2'b10;
          end
        ARB_GNT0, ARB_GNT1:
          if (!cyc_x) begin
            state <= ARB_IDLE;
            gnt <= 2'b00;
          end else if (expire) begin
            state <= ARB_ABORT;
            gnt <= 2'b00;
          end
        ARB_ABORT:
          if (!last_cyc) state <= ARB_IDLE;
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of grant order, handover, timeout and reset
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] gnt;
  int total = 0;
  int bad = 0;
  wb_arbiter_if m0 ();
  wb_arbiter_if m1 ();
  wb_arbiter_if s ();
  wb_arbiter #(.TIMEOUT_CYCLES(8), .TO_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .m0(m0.slave), .m1(m1.slave), .wb(s.master), .gnt(gnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  initial begin
    {m0.cyc, m0.stb, m0.we, m0.sel, m0.adr, m0.dat_w} = '0;
    {m1.cyc, m1.stb, m1.we, m1.sel, m1.adr, m1.dat_w} = '0;
    {s.ack, s.err, s.dat_r} = '0;
    m0.cyc = 1'b1;
    m1.cyc = 1'b1;
    tick();
    chk("rst_gnt_a", 32'(gnt), 32'h0);
    chk("rst_cyc_a", 32'(s.cyc), 32'h0);
    tick();
    chk("rst_gnt_b", 32'(gnt), 32'h0);
    chk("rst_cyc_b", 32'(s.cyc), 32'h0);
    rst = 1'b0;
    tick();
    chk("rel_gnt0", 32'(gnt), 32'h1);
    m0.cyc = 1'b0;
    m1.cyc = 1'b0;
    tick();
    chk("rel_idle", 32'(gnt), 32'h0);
    // single m0 read with a three-cycle slave wait
    m0.cyc = 1'b1; m0.stb = 1'b1; m0.sel = 4'hf; m0.adr = 32'h100;
    tick();
    chk("rd_gnt", 32'(gnt), 32'h1);
    chk("rd_cyc", 32'(s.cyc), 32'h1);
    chk("rd_stb", 32'(s.stb), 32'h1);
    chk("rd_adr", s.adr, 32'h100);
    chk("rd_noack", 32'(m0.ack), 32'h0);
    tick();
    chk("rd_wait1", 32'(m0.ack), 32'h0);
    tick();
    chk("rd_wait2", 32'(m0.ack), 32'h0);
    tick();
    s.ack = 1'b1; s.dat_r = 32'hDEADBEEF;
    #1;
    chk("rd_ack", 32'(m0.ack), 32'h1);
    chk("rd_dat", m0.dat_r, 32'hDEADBEEF);
    chk("rd_m1ack", 32'(m1.ack), 32'h0);
    tick();
    s.ack = 1'b0; m0.cyc = 1'b0; m0.stb = 1'b0;
    #1;
    chk("rd_drop_cyc", 32'(s.cyc), 32'h0);
    tick();
    chk("rd_end_gnt", 32'(gnt), 32'h0);
    // both request: one access each, alternating with a dead cycle
    m0.cyc = 1'b1; m0.stb = 1'b1; m1.cyc = 1'b1; m1.stb = 1'b1; s.ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_gnt", 32'(gnt), (i % 2) ? 32'h0 : (i % 4 == 0) ? 32'h2 : 32'h1);
      if (i % 2 == 0) begin
        chk("rr_ack", 32'({m1.ack, m0.ack}), (i % 4 == 0) ? 32'h2 : 32'h1);
        #1;
        if (i % 4 == 0) {m1.cyc, m1.stb} = 2'b00;
        else {m0.cyc, m0.stb} = 2'b00;
      end else begin
        {m0.cyc, m0.stb, m1.cyc, m1.stb} = 4'hf;
      end
    end
    {m0.cyc, m0.stb, m1.cyc, m1.stb, s.ack} = 5'b0;
    tick();
    chk("rr_end", 32'(gnt), 32'h0);
    // m1 burst is not preempted by a late m0 request
    m1.cyc = 1'b1; m1.stb = 1'b1;
    tick();
    chk("bu_gnt1", 32'(gnt), 32'h2);
    m0.cyc = 1'b1; m0.stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s.ack = 1'b1;
      #1;
      chk("bu_m1ack", 32'(m1.ack), 32'h1);
      chk("bu_m0ack", 32'(m0.ack), 32'h0);
      tick();
      chk("bu_hold", 32'(gnt), 32'h2);
    end
    s.ack = 1'b0; m1.cyc = 1'b0; m1.stb = 1'b0;
    #1;
    chk("bu_drop", 32'(s.cyc), 32'h0);
    tick();
    chk("bu_dead", 32'(gnt), 32'h0);
    tick();
    chk("bu_gnt0", 32'(gnt), 32'h1);
    m0.cyc = 1'b0; m0.stb = 1'b0;
    tick();
    // timeout: err on the 8th stalled strobe cycle, then ABORT
    m0.cyc = 1'b1; m0.stb = 1'b1;
    tick();
    for (int k = 1; k < 8; k++) begin
      chk("to_noerr", 32'(m0.err), 32'h0);
      tick();
    end
    chk("to_err", 32'(m0.err), 32'h1);
    chk("to_err_m1", 32'(m1.err), 32'h0);
    tick();
    chk("to_abort_cyc", 32'(s.cyc), 32'h0);
    chk("to_abort_gnt", 32'(gnt), 32'h0);
    chk("to_abort_err", 32'(m0.err), 32'h0);
    tick();
    chk("to_abort_hold", 32'(s.cyc), 32'h0);
    m0.cyc = 1'b0; m0.stb = 1'b0;
    tick();
    m0.cyc = 1'b1; m0.stb = 1'b1;
    tick();
    chk("to_regrant", 32'(gnt), 32'h1);
    for (int k = 1; k < 8; k++) begin
      chk("ta_noerr", 32'(m0.err), 32'h0);
      tick();
    end
    s.ack = 1'b1;
    #1;
    chk("ta_ack", 32'(m0.ack), 32'h1);
    chk("ta_err", 32'(m0.err), 32'h0);
    tick();
    chk("ta_stay", 32'(gnt), 32'h1);
    s.ack = 1'b0; m0.cyc = 1'b0; m0.stb = 1'b0;
    tick();
    // reset while m1 holds the bus mid-wait
    m1.cyc = 1'b1; m1.stb = 1'b1;
    tick();
    chk("rs_gnt1", 32'(gnt), 32'h2);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rs_cyc", 32'(s.cyc), 32'h0);
    chk("rs_gnt", 32'(gnt), 32'h0);
    chk("rs_wd", 32'(dut.u_wd.cnt), 32'h0);
    rst = 1'b0;
    tick();
    chk("rs_regrant", 32'(gnt), 32'h2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
